downselect_framer: RTL and testbench
====================================

Name: downselect_framer

Overview:
- Sits directly downstream of the channel downselection stage.
- Consumes its filtered sample stream: tuser[10:0] is the channel index, tlast marks the end of a downselected frame, and eob_downselect is the end-of-burst flag.
- Wraps each frame into a self-describing packet (header, data, trailer) for the RFNoC output path.
- Splits frames longer than MAX_SAMPS into several packets.

Parameters:
- DATA_WIDTH, 32, sample and word width; must be >= 32. Header and trailer words are LSB-aligned and zero-extended.
- MAX_SAMPS, 256, maximum data words per packet, range 1..65535.
- SYNC_BYTE, 8'hA5, constant placed in header bits [31:24].

Ports:
- clk  in  1  clock.
- sync_reset_n  in  1  synchronous active-low reset.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tdata  in  DATA_WIDTH  input sample.
- s_axis_tuser  in  24  [10:0] channel index; other bits ignored.
- s_axis_tlast  in  1  last sample of a downselected frame.
- eob_downselect  in  1  end-of-burst tag, qualified by the input transfer.
- s_axis_tready  out  1  input ready.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  DATA_WIDTH  header, sample or trailer word.
- m_axis_tlast  out  1  set on the trailer word only.
- m_axis_tready  in  1  output ready.
- frame_seq  out  8  sequence number of the packet currently being built.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: sync_reset_n sampled low at a clk edge resets the block.
- Reset state:
  - FSM goes to S_HEAD; seq=0, count=0, eob_acc=0, skid emptied.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_seq=0.
  - s_axis_tready=0 while reset is asserted.
- Reset mid-packet: the partial packet is discarded. Downstream never sees its trailer or tlast.
- Output side is a 2-entry skid register, so all m_axis_* outputs are registered.
  - Latency is 1 cycle from an internal word to m_axis_tvalid.
  - Full throughput: 1 word per cycle while m_axis_tready=1.
  - The skid is not ready when it holds 2 entries.
- An input transfer occurs when s_axis_tvalid & s_axis_tready. An internal push occurs when an internal word is valid and the skid is ready.
- S_HEAD:
  - s_axis_tready=0.
  - When s_axis_tvalid=1, push header = {SYNC_BYTE, seq, 5'b0, s_axis_tuser[10:0]}. The input sample is only peeked, not consumed.
  - On push, go to S_DATA.
- S_DATA:
  - s_axis_tready = skid ready. The input sample is pushed unmodified.
  - Each transfer: count+1, and eob_acc |= eob_downselect.
  - Go to S_TRAIL after a transfer if s_axis_tlast=1 or count+1 == MAX_SAMPS.
  - split_flag is latched at that transfer as (count+1 == MAX_SAMPS) & ~s_axis_tlast.
- S_TRAIL:
  - s_axis_tready=0.
  - Push trailer = {eob_acc, split_flag, 6'b0, seq, count[15:0]} with tlast=1.
  - On push: seq+1 (wraps 255 to 0), count=0, eob_acc=0, go to S_HEAD.
- A split continuation packet gets a fresh header, using the channel index of its first sample.
- frame_seq always equals seq.
- Zero-length packets never occur, because a header is only emitted when a sample is waiting.
- Simultaneous tlast and MAX_SAMPS boundary: a single trailer with split=0.
- Backpressure: input stalls only through s_axis_tready. No word is ever dropped or duplicated.
- s_axis_tvalid deasserting while in S_HEAD after the header was pushed is legal. The FSM waits in S_DATA.

Decomposition:
- Shared package holds:
  - FSM state enumeration (S_HEAD, S_DATA, S_TRAIL).
  - Header and trailer field offsets: SYNC [31:24], SEQ [23:16], CHAN [10:0], EOB bit 31, SPLIT bit 30, COUNT [15:0].
- One sub-module: axi_skid_2, a parameterised 2-entry registered skid buffer carrying {tlast, tdata}, with the same clk/sync_reset_n convention. It is reused elsewhere in the channelizer.

Test Plan:
- Single frame, MAX_SAMPS=256, 4 samples ch 5,9,12,40, last tlast=1, eob=0, tready=1:
  - Output is exactly 6 words: 0xA500_0005, the 4 samples, then trailer 0x0000_0004 with tlast=1.
  - frame_seq goes 0 to 1.
- MAX_SAMPS=4, 10-sample frame, first ch 3, eob on the last sample:
  - Packet 1: header 0xA500_0003, 4 samples, trailer 0x4000_0004.
  - Packet 2: header 0xA501_xxxx, 4 samples, trailer 0x4001_0004.
  - Packet 3: 2 samples, trailer 0x8002_0002.
- Boundary coincidence, MAX_SAMPS=4, frame of exactly 4 samples:
  - Trailer 0x0000_0004 (split=0).
  - Only one header is emitted.
- Random m_axis_tready, 30% low, over 1000 frames of random length 1..600:
  - Scoreboard confirms all samples are in order and counts are correct.
  - seq wraps 255 to 0.
  - m_axis_* stays stable while m_axis_tvalid=1 and m_axis_tready=0.
- Reset asserted (sync_reset_n=0) for 1 cycle mid-S_DATA:
  - Next cycle: m_axis_tvalid=0 and frame_seq=0.
  - Next packet starts with header seq 0.
  - No stray trailer is emitted.
- Input gaps, with s_axis_tvalid toggling every cycle:
  - Output packet content is identical to the gap-free run; only timing differs.

Source files
------------

// File: rtl/downselect_framer_pkg.sv
// Shared types and field layout for the downselect framer packet format.
package downselect_framer_pkg;

    typedef enum logic [1:0] {
        S_HEAD  = 2'd0,
        S_DATA  = 2'd1,
        S_TRAIL = 2'd2
    } state_t;

    // Header: SYNC [31:24], SEQ [23:16], CHAN [10:0]
    localparam int unsigned HDR_SYNC_LSB  = 24;
    localparam int unsigned HDR_SEQ_LSB   = 16;
    localparam int unsigned CHAN_W        = 11;

    // Trailer: EOB bit 31, SPLIT bit 30, SEQ [23:16], COUNT [15:0]
    localparam int unsigned TRL_EOB_BIT   = 31;
    localparam int unsigned TRL_SPLIT_BIT = 30;
    localparam int unsigned TRL_SEQ_LSB   = 16;
    localparam int unsigned COUNT_W       = 16;

    function automatic logic [31:0] make_header(input logic [7:0]        sync,
                                                input logic [7:0]        seq,
                                                input logic [CHAN_W-1:0] chan);
        logic [31:0] w;
        w = '0;
        w[HDR_SYNC_LSB +: 8]  = sync;
        w[HDR_SEQ_LSB +: 8]   = seq;
        w[CHAN_W-1:0]         = chan;
        return w;
    endfunction

    function automatic logic [31:0] make_trailer(input logic               eob,
                                                 input logic               split,
                                                 input logic [7:0]         seq,
                                                 input logic [COUNT_W-1:0] count);
        logic [31:0] w;
        w = '0;
        w[TRL_EOB_BIT]        = eob;
        w[TRL_SPLIT_BIT]      = split;
        w[TRL_SEQ_LSB +: 8]   = seq;
        w[COUNT_W-1:0]        = count;
        return w;
    endfunction

endpackage

// File: rtl/downselect_framer_skid.sv
// Two-entry registered skid buffer; outputs come straight from flops.
module axi_skid_2 #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             sync_reset_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             push;

    // Not ready only when both entries are occupied.
    assign in_ready_o  = ~skid_valid_q;
    assign push        = in_valid_i & in_ready_o;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    // Refill the output slot from the skid entry first, else from the input.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (!out_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                out_data_q   <= skid_data_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= push;
                if (push) begin
                    out_data_q <= in_data_i;
                end
            end
        end else if (push) begin
            skid_data_q  <= in_data_i;
            skid_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/downselect_framer.sv
// Wraps downselected frames into header/data/trailer packets, splitting long frames.
module downselect_framer
    import downselect_framer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_SAMPS  = 256,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  sync_reset_n,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [23:0]           s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  eob_downselect,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [7:0]            frame_seq
);

    state_t               state_q, state_d;
    logic [7:0]           seq_q, seq_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 eob_acc_q, eob_acc_d;
    logic                 split_q, split_d;

    logic                 int_valid;
    logic [DATA_WIDTH-1:0] int_data;
    logic                 int_last;
    logic                 skid_ready;
    logic                 tready_c;
    logic                 xfer;
    logic [COUNT_W:0]     count_inc;
    logic                 at_max;
    logic [DATA_WIDTH:0]  skid_out;
    logic                 unused_tuser;

    assign unused_tuser = ^s_axis_tuser[23:CHAN_W];

    assign count_inc = {1'b0, count_q} + 1'b1;
    assign at_max    = (count_inc == (COUNT_W+1)'(MAX_SAMPS));
    assign xfer      = s_axis_tvalid & s_axis_tready;

    // Next-state, internal word selection and input ready.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        count_d   = count_q;
        eob_acc_d = eob_acc_q;
        split_d   = split_q;
        int_valid = 1'b0;
        int_data  = '0;
        int_last  = 1'b0;
        tready_c  = 1'b0;
        case (state_q)
            S_HEAD: begin
                // Header peeks the waiting sample for its channel; nothing is consumed.
                int_valid = s_axis_tvalid;
                int_data  = DATA_WIDTH'(make_header(SYNC_BYTE, seq_q, s_axis_tuser[CHAN_W-1:0]));
                if (s_axis_tvalid && skid_ready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tready_c  = skid_ready;
                int_valid = s_axis_tvalid;
                int_data  = s_axis_tdata;
                if (xfer) begin
                    count_d   = count_inc[COUNT_W-1:0];
                    eob_acc_d = eob_acc_q | eob_downselect;
                    if (s_axis_tlast || at_max) begin
                        state_d = S_TRAIL;
                        split_d = at_max & ~s_axis_tlast;
                    end
                end
            end
            S_TRAIL: begin
                int_valid = 1'b1;
                int_last  = 1'b1;
                int_data  = DATA_WIDTH'(make_trailer(eob_acc_q, split_q, seq_q, count_q));
                if (skid_ready) begin
                    seq_d     = seq_q + 8'd1;
                    count_d   = '0;
                    eob_acc_d = 1'b0;
                    state_d   = S_HEAD;
                end
            end
            default: state_d = S_HEAD;
        endcase
    end

    // Framing state registers.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_q   <= S_HEAD;
            seq_q     <= '0;
            count_q   <= '0;
            eob_acc_q <= 1'b0;
            split_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            count_q   <= count_d;
            eob_acc_q <= eob_acc_d;
            split_q   <= split_d;
        end
    end

    assign s_axis_tready = sync_reset_n & tready_c;
    assign frame_seq     = seq_q;

    axi_skid_2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk         (clk),
        .sync_reset_n(sync_reset_n),
        .in_valid_i  (int_valid),
        .in_data_i   ({int_last, int_data}),
        .in_ready_o  (skid_ready),
        .out_valid_o (m_axis_tvalid),
        .out_data_o  (skid_out),
        .out_ready_i (m_axis_tready)
    );

    assign m_axis_tlast = skid_out[DATA_WIDTH];
    assign m_axis_tdata = skid_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_downselect_framer.sv
// Scoreboard bench: dut0 uses MAX_SAMPS=256, dut1 uses MAX_SAMPS=4.
module tb_downselect_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid [2];
    logic [31:0] s_tdata  [2];
    logic [23:0] s_tuser  [2];
    logic        s_tlast  [2];
    logic        s_eob    [2];
    logic        s_tready [2];
    logic        m_tvalid [2];
    logic [31:0] m_tdata  [2];
    logic        m_tlast  [2];
    logic        m_tready [2];
    logic [7:0]  fseq     [2];

    int          total = 0;
    int          passed = 0;
    bit          abort = 0;
    bit          rnd_ready = 0;
    bit          ign [2];
    logic [7:0]  mseq [2];

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    logic [31:0] fdata [$];
    logic [23:0] fuser [$];
    logic        feob  [$];

    always #5 clk = ~clk;

    downselect_framer #(.DATA_WIDTH(32), .MAX_SAMPS(256), .SYNC_BYTE(8'hA5)) dut0 (
        .clk(clk), .sync_reset_n(rst_n),
        .s_axis_tvalid(s_tvalid[0]), .s_axis_tdata(s_tdata[0]), .s_axis_tuser(s_tuser[0]),
        .s_axis_tlast(s_tlast[0]), .eob_downselect(s_eob[0]), .s_axis_tready(s_tready[0]),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tdata(m_tdata[0]), .m_axis_tlast(m_tlast[0]),
        .m_axis_tready(m_tready[0]), .frame_seq(fseq[0]));

    downselect_framer #(.DATA_WIDTH(32), .MAX_SAMPS(4), .SYNC_BYTE(8'hA5)) dut1 (
        .clk(clk), .sync_reset_n(rst_n),
        .s_axis_tvalid(s_tvalid[1]), .s_axis_tdata(s_tdata[1]), .s_axis_tuser(s_tuser[1]),
        .s_axis_tlast(s_tlast[1]), .eob_downselect(s_eob[1]), .s_axis_tready(s_tready[1]),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tdata(m_tdata[1]), .m_axis_tlast(m_tlast[1]),
        .m_axis_tready(m_tready[1]), .frame_seq(fseq[1]));

    function automatic int max_of(input int d);
        return (d == 0) ? 256 : 4;
    endfunction

    function automatic void exp_push(input int d, input logic [32:0] v);
        if (d == 0) q0.push_back(v); else q1.push_back(v);
    endfunction

    function automatic logic [32:0] exp_pop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic int exp_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: cut the frame into chunks of at most MAX, wrap each chunk.
    function automatic void model_frame(input int d);
        int n = fdata.size();
        int pos = 0;
        int mx = max_of(d);
        while (pos < n) begin
            int len = (n - pos > mx) ? mx : n - pos;
            logic e = 1'b0;
            logic sp = (pos + len < n);
            exp_push(d, {1'b0, 8'hA5, mseq[d], 5'b0, fuser[pos][10:0]});
            for (int k = 0; k < len; k++) begin
                exp_push(d, {1'b0, fdata[pos + k]});
                e = e | feob[pos + k];
            end
            exp_push(d, {1'b1, e, sp, 6'b0, mseq[d], 16'(len)});
            mseq[d] = mseq[d] + 8'd1;
            pos += len;
        end
    endfunction

    task automatic gen_random(input int n);
        fdata.delete(); fuser.delete(); feob.delete();
        for (int i = 0; i < n; i++) begin
            fdata.push_back($urandom);
            fuser.push_back(24'($urandom));
            feob.push_back($urandom_range(0, 9) == 0);
        end
    endtask

    // Drives samples [0, lim) of the current frame; called and returning on a negedge.
    task automatic drive_frame(input int d, input int lim, input bit gaps);
        int n = fdata.size();
        for (int i = 0; i < lim && !abort; i++) begin
            int cyc = 0;
            s_tvalid[d] = 1'b1;
            s_tdata[d]  = fdata[i];
            s_tuser[d]  = fuser[i];
            s_tlast[d]  = (i == n - 1);
            s_eob[d]    = feob[i];
            #1;
            while (!s_tready[d] && !abort) begin
                @(negedge clk);
                cyc++;
                if (cyc > 1000) begin
                    $display("FAIL input_stall: got tready stuck low expected transfer within 1000 cycles");
                    total++;
                    abort = 1;
                end
            end
            @(negedge clk);
            if (gaps) begin
                s_tvalid[d] = 1'b0;
                @(negedge clk);
            end
        end
        s_tvalid[d] = 1'b0;
        s_tlast[d]  = 1'b0;
        s_eob[d]    = 1'b0;
    endtask

    task automatic drain(input int d);
        int cyc = 0;
        while (exp_size(d) != 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_empty", 64'(exp_size(d)), 64'd0);
        if (exp_size(d) != 0) abort = 1;
        @(negedge clk);
        check("idle_tvalid", 64'(m_tvalid[d]), 64'd0);
        check("frame_seq", 64'(fseq[d]), 64'(mseq[d]));
    endtask

    // Output ready pattern, changed shortly after each rising edge.
    initial begin
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < 2; d++)
                m_tready[d] = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability.
    initial begin : mon
        bit          stall [2];
        logic [32:0] held  [2];
        logic [32:0] e;
        stall[0] = 0; stall[1] = 0;
        held[0] = '0; held[1] = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!ign[d] && rst_n === 1'b1) begin
                    if (stall[d])
                        check("stall_stable", {31'b0, m_tvalid[d], m_tlast[d], m_tdata[d]},
                              {31'b0, 1'b1, held[d]});
                    if (m_tvalid[d] && m_tready[d]) begin
                        if (exp_size(d) == 0) begin
                            check("unexpected_word", {31'b0, m_tlast[d], m_tdata[d]}, 64'hDEAD_0000_0000);
                        end else begin
                            e = exp_pop(d);
                            check("out_word", {31'b0, m_tlast[d], m_tdata[d]}, {31'b0, e});
                        end
                    end
                    stall[d] = m_tvalid[d] && !m_tready[d];
                end else begin
                    stall[d] = 0;
                end
                held[d] = {m_tlast[d], m_tdata[d]};
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_tvalid[d] = 0; s_tdata[d] = '0; s_tuser[d] = '0;
            s_tlast[d] = 0; s_eob[d] = 0; ign[d] = 0; mseq[d] = 8'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_tvalid", 64'(m_tvalid[d]), 64'd0);
            check("rst_tlast", 64'(m_tlast[d]), 64'd0);
            check("rst_tdata", 64'(m_tdata[d]), 64'd0);
            check("rst_frame_seq", 64'(fseq[d]), 64'd0);
            check("rst_tready", 64'(s_tready[d]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Single 4-sample frame, channels 5,9,12,40.
        fdata.delete(); fuser.delete(); feob.delete();
        fuser.push_back(24'd5); fuser.push_back(24'd9);
        fuser.push_back(24'd12); fuser.push_back(24'd40);
        for (int i = 0; i < 4; i++) begin
            fdata.push_back($urandom);
            feob.push_back(1'b0);
        end
        model_frame(0);
        check("t1_header", 64'(q0[0]), 64'h0_A500_0005);
        check("t1_trailer", 64'(q0[5]), 64'h1_0000_0004);
        drive_frame(0, 4, 0);
        drain(0);
        check("t1_seq_after", 64'(fseq[0]), 64'd1);

        // 10-sample frame through MAX_SAMPS=4, eob on last sample.
        if (!abort) begin
            gen_random(10);
            fuser[0] = 24'd3;
            for (int i = 0; i < 10; i++) feob[i] = (i == 9);
            model_frame(1);
            check("t2_trl1", 64'(q1[5]), 64'h1_4000_0004);
            check("t2_trl2", 64'(q1[11]), 64'h1_4001_0004);
            check("t2_trl3", 64'(q1[15]), 64'h1_8002_0002);
            drive_frame(1, 10, 0);
            drain(1);
        end

        // Frame exactly MAX_SAMPS long: one header, split clear.
        if (!abort) begin
            gen_random(4);
            for (int i = 0; i < 4; i++) feob[i] = 1'b0;
            model_frame(1);
            check("t3_len", 64'(q1.size()), 64'd6);
            drive_frame(1, 4, 0);
            drain(1);
        end

        // Same content with and without input gaps.
        if (!abort) begin
            gen_random(300);
            model_frame(0);
            drive_frame(0, 300, 0);
            drain(0);
            model_frame(0);
            drive_frame(0, 300, 1);
            drain(0);
        end

        // Random frames under random output backpressure.
        rnd_ready = 1;
        for (int f = 0; f < 1000 && !abort; f++) begin
            int n = ($urandom_range(0, 24) == 0) ? $urandom_range(1, 600) : $urandom_range(1, 24);
            gen_random(n);
            model_frame(0);
            drive_frame(0, n, $urandom_range(0, 3) == 0);
            drain(0);
        end
        rnd_ready = 0;
        @(negedge clk);

        // Reset in the middle of a frame.
        if (!abort) begin
            gen_random(10);
            ign[0] = 1;
            drive_frame(0, 3, 0);
            rst_n = 1'b0;
            #1;
            check("midrst_tready", 64'(s_tready[0]), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            check("midrst_tvalid", 64'(m_tvalid[0]), 64'd0);
            check("midrst_frame_seq", 64'(fseq[0]), 64'd0);
            q0.delete(); q1.delete();
            mseq[0] = 8'd0; mseq[1] = 8'd0;
            ign[0] = 0;
            gen_random(7);
            model_frame(0);
            check("midrst_header", 64'(q0[0][32:16]), 64'h0_A500);
            drive_frame(0, 7, 0);
            drain(0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
